tap_player: RTL
===============

Name: tap_player

Overview:
- Cassette (C2N) emulation stage that sits upstream of the VIC-20 core's cassette inputs.
- Consumes a .TAP image byte stream. A PRG/TAP downloader or SDRAM fetcher supplies the bytes through a valid/ready handshake into an internal 16-entry FIFO.
- Parses the 20-byte header, then converts each pulse record into a square wave on the cassette read line, timed in CPU cycles.
- Tape advances only while the motor is on and PLAY is held.

Parameters:
- FIFO_DEPTH, 16, FIFO entries (power of two).
- SIG, "C64-TAPE-RAW", 12-byte required header signature.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_ce  in  1  one-clk_sys strobe per VIC-20 CPU cycle
- din  in  8  TAP byte
- din_valid  in  1  din holds a byte
- din_ready  out  1  FIFO can accept; a byte transfers when din_valid & din_ready
- play  in  1  PLAY key held (level)
- cass_motor  in  1  motor on (active-high, already decoded from VIA)
- cass_read  out  1  tape read signal to VIA CA1; falling edge marks pulse start
- cass_sense  out  1  0 when play=1, else 1 (combinational)
- playing  out  1  pulse engine running (state PULSE, motor on, play)
- done  out  1  data length exhausted
- error  out  1  header signature mismatch

Behaviour:
- Reset values: cass_read=1, playing=0, done=0, error=0, din_ready=1 (FIFO empty), state=HDR, byte index=0. Reset mid-play discards the FIFO, the counters and the version.
- FIFO:
  - din_ready = !full.
  - A push and a pop in the same cycle are both performed.
  - A pop happens only when the engine requests a byte and the FIFO is not empty.
  - Header bytes are popped regardless of motor/play; data bytes are popped only while advancing.
- Advance condition: adv = cpu_ce & cass_motor & play.
- HDR state:
  - Pops 20 bytes; index 0..19.
  - Bytes 0-11 are compared with SIG; any mismatch sets the error flag.
  - Byte 12 latches version (only bit0 is used: 0 = v0, 1 = v1).
  - Bytes 16-19 latch the 32-bit little-endian data length LEN.
  - After byte 19: go to ERR if the error flag is set, else to FETCH.
- ERR state:
  - error=1; keeps popping and discarding bytes so upstream never stalls.
  - cass_read=1. Exits only on reset.
- FETCH state (waits for adv and a non-empty FIFO, pops one byte b, data counter +1):
  - b≠0: period P = b×8; go to PULSE.
  - b=0, v0: P = 2048; go to PULSE.
  - b=0, v1: go to LONG0.
- LONG0, LONG1, LONG2:
  - Each pops one byte (data counter +1), assembling a 24-bit little-endian count C.
  - After LONG2: if C=0, no pulse is produced and the state returns to FETCH; else P=C, go to PULSE.
  - These states do not wait for adv, only for FIFO data.
- PULSE state:
  - On entry, remaining R=P; a half value H = P>>1 is latched.
  - cass_read = 0 while R > H, else 1. The first cycle of every pulse therefore drives 0, giving a falling edge.
  - R decrements by 1 on each adv. When R reaches 1 and adv is asserted, the next state is FETCH (or DONE per the length rule).
  - Motor off or play=0 freezes R and cass_read mid-pulse.
- Underrun: in FETCH with an empty FIFO, cass_read holds 1 and the engine waits; there is no timeout.
- Length rule:
  - When the data counter equals LEN (LEN≠0) at the end of a pulse, or after consuming a zero-count long record, go to DONE.
  - LEN=0 means unlimited.
- DONE state: done=1, cass_read=1; pops are stopped, so din_ready drops once the FIFO fills.
- Widths: P and R are 24-bit; the data counter is 32-bit. b×8 fits in 11 bits and is zero-extended.

Test Plan:
- Valid v0 header (LEN=3) then data 0x30, 0x30, 0x00, with motor=1, play=1, cpu_ce every 32 clk -> two periods of 384 CPU cycles (cass_read low 192 / high 192), then one of 2048; done=1 after the third period.
- v1 header, data 0x00,0x40,0x1F,0x00 -> one pulse of 0x001F40 = 8000 CPU cycles, low 4000; next byte 0x00,0,0,0 -> no pulse, returns to FETCH with cass_read=1.
- Header byte 3 = 'X' -> error=1 after byte 19; din_ready stays 1 for 100 further bytes; cass_read stays 1.
- Mid-pulse, drop cass_motor for 500 cpu_ce -> R and cass_read unchanged; resume -> pulse completes with total active cycles = P.
- Push 16 bytes with play=0 after the header -> din_ready=0 on the 16th; set play=1 -> a pop within one adv and din_ready=1 the next clk. A simultaneous push/pop at 15 entries keeps the count at 15.
- Assert reset during PULSE -> next clk: cass_read=1, done=0, error=0, FIFO empty; a fresh header is parsed correctly.

Source files
------------

// File: rtl/tap_player.sv
// Cassette emulation: parses a .TAP byte stream from a small FIFO and replays
// each pulse record as a square wave on cass_read, timed in CPU cycles.
module tap_player #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [95:0] SIG        = "C64-TAPE-RAW"
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       cpu_ce,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       play,
  input  logic       cass_motor,
  output logic       cass_read,
  output logic       cass_sense,
  output logic       playing,
  output logic       done,
  output logic       error
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_ERR   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_LONG0 = 3'd3;
  localparam logic [2:0] S_LONG1 = 3'd4;
  localparam logic [2:0] S_LONG2 = 3'd5;
  localparam logic [2:0] S_PULSE = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, pop_req;
  logic [7:0]    head;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign din_ready = !full;
  assign push      = din_valid & din_ready;
  assign pop       = pop_req & !empty;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  logic [7:0] sig_bytes [12];
  for (genvar g = 0; g < 12; g++) begin : g_sig
    assign sig_bytes[g] = SIG[8*(11-g) +: 8];
  end

  logic [2:0]  state, state_nxt;
  logic [4:0]  idx, idx_nxt;
  logic        err_flag, err_flag_nxt;
  logic        ver, ver_nxt;
  logic [31:0] len, len_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [15:0] lcount, lcount_nxt;
  logic [23:0] r, r_nxt, h, h_nxt;
  logic [23:0] p_load, long_c;
  logic        adv;

  assign adv        = cpu_ce & cass_motor & play;
  assign cass_sense = !play;
  assign playing    = (state == S_PULSE) & cass_motor & play;
  assign long_c     = {head, lcount};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= S_HDR;
      idx       <= '0;
      err_flag  <= 1'b0;
      ver       <= 1'b0;
      len       <= '0;
      cnt       <= '0;
      lcount    <= '0;
      r         <= '0;
      h         <= '0;
      cass_read <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      err_flag  <= err_flag_nxt;
      ver       <= ver_nxt;
      len       <= len_nxt;
      cnt       <= cnt_nxt;
      lcount    <= lcount_nxt;
      r         <= r_nxt;
      h         <= h_nxt;
      cass_read <= !((state_nxt == S_PULSE) && (r_nxt > h_nxt));
      done      <= (state_nxt == S_DONE);
      error     <= (state_nxt == S_ERR);
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    err_flag_nxt = err_flag;
    ver_nxt      = ver;
    len_nxt      = len;
    cnt_nxt      = cnt;
    lcount_nxt   = lcount;
    r_nxt        = r;
    h_nxt        = h;
    pop_req      = 1'b0;
    p_load       = '0;

    case (state)
      S_HDR: begin
        pop_req = 1'b1;
        if (!empty) begin
          idx_nxt = idx + 5'd1;
          if ((idx < 5'd12) && (head != sig_bytes[idx[3:0]])) err_flag_nxt = 1'b1;
          if (idx == 5'd12) ver_nxt = head[0];
          if (idx >= 5'd16) begin
            case (idx[1:0])
              2'd0:    len_nxt[7:0]   = head;
              2'd1:    len_nxt[15:8]  = head;
              2'd2:    len_nxt[23:16] = head;
              default: len_nxt[31:24] = head;
            endcase
          end
          if (idx == 5'd19) state_nxt = err_flag_nxt ? S_ERR : S_FETCH;
        end
      end

      // Drain forever so the upstream fetcher never stalls on a bad image
      S_ERR: pop_req = 1'b1;

      S_FETCH: begin
        pop_req = adv;
        if (adv && !empty) begin
          cnt_nxt = cnt + 32'd1;
          if (head != 8'd0 || !ver) begin
            p_load    = (head != 8'd0) ? {13'd0, head, 3'd0} : 24'd2048;
            r_nxt     = p_load;
            h_nxt     = p_load >> 1;
            state_nxt = S_PULSE;
          end else begin
            state_nxt = S_LONG0;
          end
        end
      end

      S_LONG0, S_LONG1: begin
        pop_req = 1'b1;
        if (!empty) begin
          cnt_nxt = cnt + 32'd1;
          if (state == S_LONG0) begin
            lcount_nxt[7:0] = head;
            state_nxt       = S_LONG1;
          end else begin
            lcount_nxt[15:8] = head;
            state_nxt        = S_LONG2;
          end
        end
      end

      S_LONG2: begin
        pop_req = 1'b1;
        if (!empty) begin
          cnt_nxt = cnt + 32'd1;
          if (long_c == 24'd0) begin
            state_nxt = ((len != 32'd0) && (cnt_nxt == len)) ? S_DONE : S_FETCH;
          end else begin
            r_nxt     = long_c;
            h_nxt     = long_c >> 1;
            state_nxt = S_PULSE;
          end
        end
      end

      // R counts down on each advancing cycle; the pulse ends on the R==1 advance
      S_PULSE: begin
        if (adv) begin
          if (r == 24'd1) begin
            state_nxt = ((len != 32'd0) && (cnt == len)) ? S_DONE : S_FETCH;
          end else begin
            r_nxt = r - 24'd1;
          end
        end
      end

      S_DONE: pop_req = 1'b0;

      default: state_nxt = S_HDR;
    endcase
  end

endmodule
